// File: rtl/sm_trace_buffer.sv
// sm_trace_buffer: circular retire-trace capture with halt/timeout freeze and ordered readout
module sm_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int HALT_CYCLES = 4,
  parameter int TIMEOUT = 120
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpuEn,
  input  logic [31:0]   pc,
  input  logic [31:0]   instr,
  input  logic [31:0]   a0,
  input  logic          clear,
  input  logic [AW-1:0] rdAddr,
  output logic [31:0]   rdPc,
  output logic [31:0]   rdInstr,
  output logic [31:0]   rdA0,
  output logic [AW:0]   count,
  output logic          wrapped,
  output logic          halted,
  output logic          timeout,
  output logic [31:0]   cycleCnt
);
  localparam int RW = $clog2(HALT_CYCLES + 1);
  logic [95:0] mem [DEPTH];
  logic [AW-1:0] wptr, physAddr;
  logic [31:0] prevPc, cntNext;
  logic prevValid, accept, full;
  logic [RW-1:0] run, runNext;
  assign accept = cpuEn & ~(halted | timeout) & ~clear;
  assign full = count == (AW+1)'(DEPTH);
  assign runNext = (prevValid && pc == prevPc) ? run + 1'b1 : RW'(1);
  assign cntNext = (cycleCnt == '1) ? cycleCnt : cycleCnt + 1'b1;
  assign physAddr = wrapped ? wptr + rdAddr : rdAddr;
  // trace storage; contents are don't-care after reset so no reset is applied
  always_ff @(posedge clk)
    if (accept) mem[wptr] <= {pc, instr, a0};
  // capture bookkeeping, halt run tracking and sticky freeze flags
  always_ff @(posedge clk or posedge rst)
    if (rst || clear) begin
      wptr <= '0;
      count <= '0;
      wrapped <= 1'b0;
      halted <= 1'b0;
      timeout <= 1'b0;
      cycleCnt <= '0;
      run <= '0;
      prevPc <= '0;
      prevValid <= 1'b0;
    end else if (accept) begin
      wptr <= wptr + 1'b1;
      count <= full ? count : count + 1'b1;
      wrapped <= wrapped | full;
      cycleCnt <= cntNext;
      run <= runNext;
      prevPc <= pc;
      prevValid <= 1'b1;
      halted <= runNext == RW'(HALT_CYCLES);
      timeout <= cntNext == 32'(TIMEOUT);
    end
  // registered readout indexed from the oldest valid entry; old data on same-slot write
  always_ff @(posedge clk or posedge rst)
    if (rst || clear) {rdPc, rdInstr, rdA0} <= '0;
    else {rdPc, rdInstr, rdA0} <= ({1'b0, rdAddr} >= count) ? '0 : mem[physAddr];
endmodule

// File: tb/tb_sm_trace_buffer.sv
// tb_sm_trace_buffer: randomized self-checking bench against a history-queue reference model
module tb_sm_trace_buffer;
  localparam int DEPTH = 16;
  localparam int HC = 4;
  localparam int TOA = 120;
  localparam int TOB = 10;
  typedef logic [95:0] ent_t;
  logic clk = 0, rst = 1, cpuEn = 0, clear = 0;
  logic [31:0] pc = 0, instr = 0, a0 = 0;
  logic [3:0] rdAddr = 0;
  logic [31:0] rdPcA, rdInstrA, rdA0A, cycleCntA, rdPcB, rdInstrB, rdA0B, cycleCntB;
  logic [4:0] countA, countB;
  logic wrappedA, haltedA, timeoutA, wrappedB, haltedB, timeoutB;
  ent_t histA[$], histB[$];
  ent_t expRdA, expRdB;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  sm_trace_buffer #(.DEPTH(DEPTH), .AW(4), .HALT_CYCLES(HC), .TIMEOUT(TOA)) dutA (
    .clk(clk), .rst(rst), .cpuEn(cpuEn), .pc(pc), .instr(instr), .a0(a0), .clear(clear),
    .rdAddr(rdAddr), .rdPc(rdPcA), .rdInstr(rdInstrA), .rdA0(rdA0A), .count(countA),
    .wrapped(wrappedA), .halted(haltedA), .timeout(timeoutA), .cycleCnt(cycleCntA));
  sm_trace_buffer #(.DEPTH(DEPTH), .AW(4), .HALT_CYCLES(HC), .TIMEOUT(TOB)) dutB (
    .clk(clk), .rst(rst), .cpuEn(cpuEn), .pc(pc), .instr(instr), .a0(a0), .clear(clear),
    .rdAddr(rdAddr), .rdPc(rdPcB), .rdInstr(rdInstrB), .rdA0(rdA0B), .count(countB),
    .wrapped(wrappedB), .halted(haltedB), .timeout(timeoutB), .cycleCnt(cycleCntB));
  function automatic int mCount(input ent_t q[$]);
    return q.size() > DEPTH ? DEPTH : q.size();
  endfunction
  function automatic bit mWrapped(input ent_t q[$]);
    return q.size() > DEPTH;
  endfunction
  function automatic bit mHalted(input ent_t q[$]);
    int n = q.size();
    if (n < HC) return 0;
    for (int i = n - HC; i < n; i++) if (q[i][95:64] != q[n-1][95:64]) return 0;
    return 1;
  endfunction
  function automatic bit mTimeout(input ent_t q[$], input int to);
    return q.size() >= to;
  endfunction
  function automatic ent_t mRead(input ent_t q[$], input int addr);
    int c = mCount(q);
    return addr < c ? q[q.size() - c + addr] : '0;
  endfunction
  task automatic step(input logic en, input logic [31:0] p, input logic clr, input logic [3:0] addr);
    cpuEn = en; pc = p; instr = $urandom; a0 = $urandom; clear = clr; rdAddr = addr;
    expRdA = clr ? '0 : mRead(histA, addr);
    expRdB = clr ? '0 : mRead(histB, addr);
    @(posedge clk);
    if (clr) begin
      histA.delete();
      histB.delete();
    end else if (en) begin
      if (!(mHalted(histA) || mTimeout(histA, TOA))) histA.push_back({p, instr, a0});
      if (!(mHalted(histB) || mTimeout(histB, TOB))) histB.push_back({p, instr, a0});
    end
    #1;
    cpuEn = 0; clear = 0;
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if ({countA, wrappedA, haltedA, timeoutA} !== '0) begin bad++; $display("FAIL reset_flags got=%h exp=0", {countA, wrappedA, haltedA, timeoutA}); end
    total++; if (cycleCntA !== 0) begin bad++; $display("FAIL reset_cycleCnt got=%0d exp=0", cycleCntA); end
    total++; if ({rdPcA, rdInstrA, rdA0A} !== '0) begin bad++; $display("FAIL reset_rd got=%h exp=0", {rdPcA, rdInstrA, rdA0A}); end
    rst = 0;
  endtask
  task automatic test_basic();
    for (int k = 0; k < 5; k++) step(1, 32'(4 * k), 0, 0);
    total++; if (countA !== 5'd5) begin bad++; $display("FAIL basic_count got=%0d exp=5", countA); end
    total++; if (wrappedA !== 1'b0) begin bad++; $display("FAIL basic_wrapped got=%0b exp=0", wrappedA); end
    total++; if (cycleCntA !== 32'd5) begin bad++; $display("FAIL basic_cycleCnt got=%0d exp=5", cycleCntA); end
    step(0, 0, 0, 2);
    total++; if (rdPcA !== 32'd8) begin bad++; $display("FAIL basic_rd2_pc got=%0d exp=8", rdPcA); end
    total++; if ({rdPcA, rdInstrA, rdA0A} !== expRdA) begin bad++; $display("FAIL basic_rd2_entry got=%h exp=%h", {rdPcA, rdInstrA, rdA0A}, expRdA); end
    step(0, 0, 0, 5);
    total++; if ({rdPcA, rdInstrA, rdA0A} !== '0) begin bad++; $display("FAIL basic_rd5_zero got=%h exp=0", {rdPcA, rdInstrA, rdA0A}); end
  endtask
  task automatic test_wrap();
    step(0, 0, 1, 0);
    for (int k = 0; k < 20; k++) step(1, 32'(4 * k), 0, 0);
    total++; if (countA !== 5'd16) begin bad++; $display("FAIL wrap_count got=%0d exp=16", countA); end
    total++; if (wrappedA !== 1'b1) begin bad++; $display("FAIL wrap_wrapped got=%0b exp=1", wrappedA); end
    total++; if (timeoutB !== 1'b1 || cycleCntB !== 32'd10) begin bad++; $display("FAIL wrap_timeoutB got=%0b/%0d exp=1/10", timeoutB, cycleCntB); end
    step(0, 0, 0, 0);
    total++; if (rdPcA !== 32'd16) begin bad++; $display("FAIL wrap_rd0_pc got=%0d exp=16", rdPcA); end
    step(0, 0, 0, 15);
    total++; if (rdPcA !== 32'd76) begin bad++; $display("FAIL wrap_rd15_pc got=%0d exp=76", rdPcA); end
    total++; if ({rdPcA, rdInstrA, rdA0A} !== expRdA) begin bad++; $display("FAIL wrap_rd15_entry got=%h exp=%h", {rdPcA, rdInstrA, rdA0A}, expRdA); end
  endtask
  task automatic test_halt();
    logic [31:0] seq [8] = '{0, 4, 8, 8, 8, 8, 8, 12};
    step(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, seq[i], 0, 0);
      total++; if (haltedA !== (i >= 5)) begin bad++; $display("FAIL halt_flag_%0d got=%0b exp=%0b", i, haltedA, i >= 5); end
    end
    total++; if (countA !== 5'd6 || countA !== 5'(mCount(histA))) begin bad++; $display("FAIL halt_count got=%0d exp=6", countA); end
    total++; if (cycleCntA !== 32'd6) begin bad++; $display("FAIL halt_cycleCnt got=%0d exp=6", cycleCntA); end
    step(1, 16, 0, 5);
    total++; if (countA !== 5'd6 || cycleCntA !== 32'd6) begin bad++; $display("FAIL halt_frozen got=%0d/%0d exp=6/6", countA, cycleCntA); end
    total++; if (rdPcA !== 32'd8 || {rdPcA, rdInstrA, rdA0A} !== expRdA) begin bad++; $display("FAIL halt_rd5 got=%h exp=%h", {rdPcA, rdInstrA, rdA0A}, expRdA); end
  endtask
  task automatic test_timeout();
    int k = 0;
    step(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      step(i % 2 == 0, 32'(4 * i), 0, 0);
      if (i % 2 == 0) k++;
      total++; if (timeoutB !== (k >= TOB)) begin bad++; $display("FAIL timeout_flag_%0d got=%0b exp=%0b", k, timeoutB, k >= TOB); end
    end
    for (int i = 0; i < 20; i++) step(1, 32'(1000 + 4 * i), 0, 0);
    total++; if (cycleCntB !== 32'd10 || timeoutB !== 1'b1) begin bad++; $display("FAIL timeout_hold got=%0d/%0b exp=10/1", cycleCntB, timeoutB); end
    total++; if (timeoutA !== 1'b0 || cycleCntA !== 32'd30) begin bad++; $display("FAIL timeout_A got=%0b/%0d exp=0/30", timeoutA, cycleCntA); end
  endtask
  task automatic test_clear();
    step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 40, 0, 0);
    total++; if (haltedA !== 1'b1) begin bad++; $display("FAIL clear_pre_halt got=%0b exp=1", haltedA); end
    step(1, 44, 1, 0);
    total++; if ({countA, wrappedA, haltedA, timeoutA} !== '0 || cycleCntA !== 0) begin bad++; $display("FAIL clear_state got=%h/%0d exp=0/0", {countA, wrappedA, haltedA, timeoutA}, cycleCntA); end
    step(1, 200, 0, 0);
    step(0, 0, 0, 0);
    total++; if (rdPcA !== 32'd200 || countA !== 5'd1) begin bad++; $display("FAIL clear_first got=%0d/%0d exp=200/1", rdPcA, countA); end
  endtask
  task automatic test_async_reset();
    step(0, 0, 1, 0);
    for (int k = 0; k < 7; k++) step(1, 32'(4 * k + 4), 0, 0);
    step(0, 0, 0, 0);
    total++; if (rdPcA !== 32'd4) begin bad++; $display("FAIL areset_pre_rd got=%0d exp=4", rdPcA); end
    #2 rst = 1;
    #1;
    total++; if ({countA, cycleCntA, rdPcA, rdInstrA, rdA0A, wrappedA} !== '0) begin bad++; $display("FAIL areset_zero got=%0d/%0d/%0d exp=0/0/0", countA, cycleCntA, rdPcA); end
    #1 rst = 0;
    histA.delete();
    histB.delete();
    step(1, 100, 0, 0);
    step(0, 0, 0, 0);
    total++; if (countA !== 5'd1 || rdPcA !== 32'd100) begin bad++; $display("FAIL areset_resume got=%0d/%0d exp=1/100", countA, rdPcA); end
  endtask
  task automatic test_random();
    logic [31:0] lastPc = 0, p;
    step(0, 0, 1, 0);
    for (int i = 0; i < 400; i++) begin
      p = ($urandom_range(0, 2) == 0) ? lastPc : {$urandom_range(0, 255), 2'b00};
      lastPc = p;
      step($urandom_range(0, 3) != 0, p, $urandom_range(0, 59) == 0, 4'($urandom_range(0, 15)));
      total++; if ({rdPcA, rdInstrA, rdA0A} !== expRdA || {rdPcB, rdInstrB, rdA0B} !== expRdB) begin bad++; $display("FAIL rand_rd_%0d got=%h exp=%h", i, {rdPcA, rdInstrA, rdA0A}, expRdA); end
      total++; if (countA !== 5'(mCount(histA)) || wrappedA !== mWrapped(histA) || cycleCntA !== 32'(histA.size())) begin bad++; $display("FAIL rand_stateA_%0d got=%0d/%0b/%0d exp=%0d/%0b/%0d", i, countA, wrappedA, cycleCntA, mCount(histA), mWrapped(histA), histA.size()); end
      total++; if (haltedA !== mHalted(histA) || timeoutA !== mTimeout(histA, TOA) || haltedB !== mHalted(histB) || timeoutB !== mTimeout(histB, TOB)) begin bad++; $display("FAIL rand_flags_%0d got=%b exp=%b", i, {haltedA, timeoutA, haltedB, timeoutB}, {mHalted(histA), mTimeout(histA, TOA), mHalted(histB), mTimeout(histB, TOB)}); end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_halt();
    test_timeout();
    test_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
